pattern_loader: RTL and testbench
=================================

Name: pattern_loader

Overview:
- Upstream serial-load sequencer for the pattern buffer.
- Accepts a frame of BUFFER_SIZE bytes from a host over a valid/ready byte interface and serialises each byte MSB-first onto the buffer's ssel/sin scan chain.
- At the same time it captures the previous buffer contents from sout and returns them as a readback byte stream.
- Asserts busy for the whole frame so the field-write path stays blocked while the chain shifts.

Parameters:
- BUFFER_SIZE, 22, bytes per frame; must equal the pattern buffer depth.
- BUFFER_WIDTH, 8, bits per byte; one shift cycle per bit.
- READBACK, 1, 1 = readback stream enabled (WAIT_OUT handshake); 0 = WAIT_OUT skipped and out_valid held 0.

Ports:
- clk  in  1  system clock; also clocks the pattern buffer.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse that begins a frame; ignored unless state is IDLE.
- in_data  in  BUFFER_WIDTH  host byte.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  loader accepts a byte this cycle.
- out_data  out  BUFFER_WIDTH  readback byte (old buffer contents).
- out_valid  out  1  out_data is valid.
- out_ready  in  1  host consumes out_data.
- ssel  out  1  shift enable to the pattern buffer.
- sin  out  1  serial data to the pattern buffer.
- sout  in  1  serial data from the pattern buffer (last field, MSB).
- busy  out  1  frame in progress; high from the start-accept edge until done.
- done  out  1  one-cycle pulse when the frame completes.

Behaviour:
- Reset (asynchronous, rst_n=0): state IDLE; ssel=0, sin=0, in_ready=0, out_valid=0, out_data=0, busy=0, done=0; byte and bit counters = 0. Reset mid-frame aborts immediately: ssel drops at once, the partly shifted buffer contents are left as they are, and no done pulse is issued.
- All outputs are registered except in_ready, which is (state==WAIT_IN).
- States: IDLE, WAIT_IN, SHIFT, WAIT_OUT.
- IDLE: when start=1, busy<=1, bytecnt<=0, go to WAIT_IN.
- WAIT_IN: on in_valid&in_ready, shreg<=in_data, ssel<=1, sin<=in_data[MSB], bitcnt<=0, go to SHIFT.
- SHIFT: on each edge, cap<={cap[W-2:0], sout}.
  - If bitcnt<W-1: sin<=next lower bit of shreg, bitcnt++.
  - If bitcnt=W-1: ssel<=0, out_data<={cap[W-2:0], sout}.
    - READBACK=1: out_valid<=1, go to WAIT_OUT.
    - READBACK=0: go straight to the end-of-byte step.
- ssel is high for exactly BUFFER_WIDTH consecutive cycles per byte, never more.
- sout is sampled at the same edges at which the buffer shifts, i.e. it is the pre-shift value.
- WAIT_OUT: on out_valid&out_ready, out_valid<=0, then do the end-of-byte step.
- End-of-byte step:
  - If bytecnt=BUFFER_SIZE-1: done<=1 for one cycle, busy<=0, go to IDLE.
  - Otherwise bytecnt++, go to WAIT_IN.
- Per-byte latency: 1 accept cycle + BUFFER_WIDTH shift cycles + at least 1 readback cycle.
- Ordering:
  - The first byte sent ends in field BUFFER_SIZE-1 and the last byte sent ends in field 0.
  - Readback returns old field BUFFER_SIZE-1 first and old field 0 last.
- Boundary cases:
  - in_valid outside WAIT_IN is ignored.
  - out_ready with out_valid=0 has no effect.
  - start while busy is ignored.
  - An indefinite stall on out_ready holds ssel=0, so the buffer keeps its contents.
- Counters are sized clog2(BUFFER_SIZE) and clog2(BUFFER_WIDTH); no wrap occurs because a frame terminates at BUFFER_SIZE bytes.

Test Plan:
- Reset check: assert rst_n=0 with random inputs -> ssel, sin, in_ready, out_valid, busy and done are all 0, with no dependence on clk.
- Single-byte shift: start, then in_data=0xA5 -> ssel high for exactly 8 cycles, sin sequence 1,0,1,0,0,1,0,1, in_ready low during the shift.
- Full frame: send bytes 0x00..0x15 with out_ready=1, buffer model attached -> buffer field 21=0x00 and field 0=0x15; done pulses once, after the 22nd byte; busy then falls.
- Readback: run a second frame of 0xFF bytes -> out_data returns 0x00,0x01,...,0x15 in order; afterwards every field is 0xFF.
- Backpressure: hold out_ready=0 for 20 cycles after the 3rd byte -> out_valid and out_data stay stable, ssel=0, in_ready=0; the frame resumes correctly on release.
- Abort: pulse rst_n=0 during the 4th bit of byte 5 -> ssel drops immediately and no done pulse occurs; a fresh start then loads a full frame correctly.

Source files
------------

// File: rtl/pattern_loader.sv
// Purpose: loads a BUFFER_SIZE-byte frame from a host byte stream into the pattern
//          buffer scan chain (MSB-first) while returning the displaced contents.
// Latency: per byte 1 accept cycle + BUFFER_WIDTH shift cycles + >=1 readback cycle.
// Backpressure: in_ready only in WAIT_IN; a stalled out_ready parks in WAIT_OUT with
//               ssel low, so the buffer holds its contents indefinitely.
//
// Ports:
//   clk, rst_n          clock (shared with the pattern buffer), async active-low reset
//   start               one-cycle frame start, honoured only when idle
//   in_data/valid/ready host byte input (in_ready is the only combinational output)
//   out_data/valid/ready readback byte output (previous buffer contents)
//   ssel, sin, sout     scan-chain shift enable, serial in, serial out (pre-shift value)
//   busy, done          frame in progress / one-cycle frame completion pulse
module pattern_loader #(
  parameter int BUFFER_SIZE  = 22,   // bytes per frame, equals buffer depth
  parameter int BUFFER_WIDTH = 8,    // bits per byte, must be >= 2
  parameter bit READBACK     = 1'b1  // 0: no readback handshake, out_valid stays 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [BUFFER_WIDTH-1:0] in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [BUFFER_WIDTH-1:0] out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    ssel,
  output logic                    sin,
  input  logic                    sout,
  output logic                    busy,
  output logic                    done
);

  localparam int W       = BUFFER_WIDTH;
  localparam int BYTE_CW = (BUFFER_SIZE > 1) ? $clog2(BUFFER_SIZE) : 1;
  localparam int BIT_CW  = (BUFFER_WIDTH > 1) ? $clog2(BUFFER_WIDTH) : 1;

  localparam logic [BYTE_CW-1:0] LAST_BYTE = BYTE_CW'(BUFFER_SIZE - 1);
  localparam logic [BIT_CW-1:0]  LAST_BIT  = BIT_CW'(BUFFER_WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_IN  = 2'd1,
    SHIFT    = 2'd2,
    WAIT_OUT = 2'd3
  } state_t;

  state_t              state_q,     state_d;
  logic [BYTE_CW-1:0]  byte_cnt_q,  byte_cnt_d;
  logic [BIT_CW-1:0]   bit_cnt_q,   bit_cnt_d;
  // The MSB leaves on sin at accept time, so only the remaining W-1 bits are kept.
  logic [W-2:0]        shreg_q,     shreg_d;
  // Capture holds the W-1 readback bits gathered before the final shift edge.
  logic [W-2:0]        cap_q,       cap_d;
  logic                ssel_q,      ssel_d;
  logic                sin_q,       sin_d;
  logic [W-1:0]        out_data_q,  out_data_d;
  logic                out_valid_q, out_valid_d;
  logic                busy_q,      busy_d;
  logic                done_q,      done_d;

  logic [W-1:0]        cap_next;
  logic                end_of_byte;

  // sout is sampled on the same edge at which the buffer shifts, so this is the
  // bit about to fall off the end of the chain.
  assign cap_next = {cap_q, sout};

  always_comb begin
    state_d     = state_q;
    byte_cnt_d  = byte_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    shreg_d     = shreg_q;
    cap_d       = cap_q;
    ssel_d      = ssel_q;
    sin_d       = sin_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    end_of_byte = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          busy_d     = 1'b1;
          byte_cnt_d = '0;
          state_d    = WAIT_IN;
        end
      end

      WAIT_IN: begin
        // in_ready is exactly this state, so in_valid alone completes the handshake.
        if (in_valid) begin
          shreg_d   = in_data[W-2:0];
          ssel_d    = 1'b1;
          sin_d     = in_data[W-1];
          bit_cnt_d = '0;
          state_d   = SHIFT;
        end
      end

      SHIFT: begin
        cap_d = cap_next[W-2:0];
        if (bit_cnt_q != LAST_BIT) begin
          sin_d     = shreg_q[W-2];
          shreg_d   = shreg_q << 1;
          bit_cnt_d = bit_cnt_q + 1'b1;
        end else begin
          // This edge performs the W-th shift; dropping ssel here caps the
          // enable at exactly W cycles.
          ssel_d     = 1'b0;
          sin_d      = 1'b0;
          out_data_d = cap_next;
          if (READBACK) begin
            out_valid_d = 1'b1;
            state_d     = WAIT_OUT;
          end else begin
            end_of_byte = 1'b1;
          end
        end
      end

      WAIT_OUT: begin
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          end_of_byte = 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase

    if (end_of_byte) begin
      if (byte_cnt_q == LAST_BYTE) begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end else begin
        byte_cnt_d = byte_cnt_q + 1'b1;
        state_d    = WAIT_IN;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      byte_cnt_q  <= '0;
      bit_cnt_q   <= '0;
      shreg_q     <= '0;
      cap_q       <= '0;
      ssel_q      <= 1'b0;
      sin_q       <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      byte_cnt_q  <= byte_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shreg_q     <= shreg_d;
      cap_q       <= cap_d;
      ssel_q      <= ssel_d;
      sin_q       <= sin_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign in_ready  = (state_q == WAIT_IN);
  assign ssel      = ssel_q;
  assign sin       = sin_q;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_pattern_loader.sv
// Bench for pattern_loader: drives frames through the loader into a behavioural
// scan-chain model of the pattern buffer and compares against hand-computed values.
// Covers reset, single-byte shift, full frames with readback, backpressure and abort.
module tb_pattern_loader;

  localparam int SIZE = 22;
  localparam int W    = 8;
  localparam int N    = SIZE * W;

  logic         clk       = 1'b0;
  logic         rst_n     = 1'b1;
  logic         start     = 1'b0;
  logic [W-1:0] in_data   = '0;
  logic         in_valid  = 1'b0;
  logic         out_ready = 1'b0;
  logic         in_ready, out_valid, ssel, sin, sout, busy, done;
  logic [W-1:0] out_data;

  int checks = 0;
  int errors = 0;

  // Pattern buffer model: sin enters field 0 LSB, sout is field SIZE-1 MSB.
  logic [N-1:0] chain = '0;
  logic [N-1:0] snap;

  typedef struct {
    logic [7:0] din;
    logic [7:0] exp_rb;
    int         stall;
  } vec_t;
  vec_t vec [66];

  always #5 clk = ~clk;

  always @(posedge clk) if (ssel) chain <= {chain[N-2:0], sin};
  assign sout = chain[N-1];

  pattern_loader #(
    .BUFFER_SIZE (SIZE),
    .BUFFER_WIDTH(W),
    .READBACK    (1'b1)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .ssel     (ssel),
    .sin      (sin),
    .sout     (sout),
    .busy     (busy),
    .done     (done)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] field_of(input logic [N-1:0] c, input int k);
    return c[k*W +: W];
  endfunction

  // Send one byte, observe the shift and the readback, then complete the handshake.
  task automatic do_byte(input int idx, input logic [7:0] b, input logic [7:0] exp_rb,
                         input int stall, input bit exp_done);
    int         t;
    int         n_ssel;
    logic [7:0] sin_seq;
    bit         leak;
    bit         bad;
    logic [7:0] held;
    t = 0;
    while (!in_ready && t < 50) begin @(negedge clk); t++; end
    check($sformatf("in_ready_wait[%0d]", idx), int'(in_ready), 1);
    out_ready = (stall == 0);
    in_data   = b;
    in_valid  = 1'b1;
    @(posedge clk); #1;
    // Keep in_valid high with junk during the shift; it must be ignored.
    in_data = ~b;
    n_ssel = 0; sin_seq = '0; leak = 0; t = 0;
    do begin
      @(negedge clk);
      if (ssel) begin
        n_ssel++;
        sin_seq = {sin_seq[6:0], sin};
        if (in_ready) leak = 1;
      end
      t++;
    end while (!out_valid && t < 40);
    in_valid = 1'b0;
    check($sformatf("out_valid_seen[%0d]", idx), int'(out_valid), 1);
    check($sformatf("ssel_low_at_readback[%0d]", idx), int'(ssel), 0);
    check($sformatf("ssel_cycles[%0d]", idx), n_ssel, 8);
    check($sformatf("sin_sequence[%0d]", idx), int'(sin_seq), int'(b));
    check($sformatf("in_ready_during_shift[%0d]", idx), int'(leak), 0);
    check($sformatf("readback[%0d]", idx), int'(out_data), int'(exp_rb));
    if (stall > 0) begin
      held = out_data;
      bad  = 0;
      repeat (stall) begin
        @(negedge clk);
        if (out_valid !== 1'b1 || out_data !== held || ssel !== 1'b0 || in_ready !== 1'b0)
          bad = 1;
      end
      check($sformatf("stall_stable[%0d]", idx), int'(bad), 0);
      out_ready = 1'b1;
    end
    @(negedge clk);
    check($sformatf("out_valid_cleared[%0d]", idx), int'(out_valid), 0);
    check($sformatf("done[%0d]", idx), int'(done), int'(exp_done));
    check($sformatf("busy[%0d]", idx), int'(busy), int'(!exp_done));
  endtask

  task automatic run_frame(input int base);
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    check($sformatf("busy_after_start[%0d]", base), int'(busy), 1);
    for (int i = 0; i < SIZE; i++)
      do_byte(base + i, vec[base+i].din, vec[base+i].exp_rb, vec[base+i].stall, (i == SIZE-1));
    @(negedge clk);
    check($sformatf("done_one_cycle[%0d]", base), int'(done), 0);
    check($sformatf("idle_in_ready[%0d]", base), int'(in_ready), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired actual=hang expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit bad;

    // Frame 1 loads 0x00..0x15; the only non-zero old field is the 0xA5 left
    // in field 0 by the single-byte test. Frame 2 loads 0xFF and reads frame 1
    // back in send order, with a 20-cycle readback stall on the third byte.
    for (int i = 0; i < SIZE; i++) begin
      vec[i].din       = 8'(i);
      vec[i].exp_rb    = (i == SIZE-1) ? 8'hA5 : 8'h00;
      vec[i].stall     = 0;
      vec[SIZE+i].din    = 8'hFF;
      vec[SIZE+i].exp_rb = 8'(i);
      vec[SIZE+i].stall  = (i == 2) ? 20 : 0;
    end

    // Asynchronous reset, checked before any clock edge, then with random inputs.
    #1 rst_n = 1'b0;
    #2;
    check("reset_async", int'({ssel, sin, in_ready, out_valid, busy, done, out_data}), 0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      start     = 1'($urandom);
      in_valid  = 1'($urandom);
      out_ready = 1'($urandom);
      in_data   = 8'($urandom);
      #2;
      check($sformatf("reset_held[%0d]", i),
            int'({ssel, sin, in_ready, out_valid, busy, done, out_data}), 0);
    end
    @(negedge clk);
    start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    rst_n = 1'b1;

    // Idle: in_valid and out_ready have no effect.
    in_valid = 1'b1; in_data = 8'h5A; out_ready = 1'b1;
    bad = 0;
    repeat (3) begin
      @(negedge clk);
      if (in_ready || ssel || busy || out_valid) bad = 1;
    end
    check("idle_ignores_inputs", int'(bad), 0);
    in_valid = 1'b0; out_ready = 1'b0;

    // Single byte 0xA5, then start while busy, then asynchronous abort.
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    check("single_busy", int'(busy), 1);
    do_byte(100, 8'hA5, 8'h00, 0, 1'b0);
    check("single_field0", int'(field_of(chain, 0)), 'hA5);
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    check("start_while_busy", int'({in_ready, busy, ssel}), 'b110);
    #2 rst_n = 1'b0;
    #1;
    check("reset_mid_frame", int'({busy, in_ready, ssel, out_valid, done}), 0);
    @(negedge clk) rst_n = 1'b1;

    // Frame 1 and frame 2 from the table.
    run_frame(0);
    for (int k = 0; k < SIZE; k++)
      check($sformatf("frame1_field[%0d]", k), int'(field_of(chain, k)), SIZE-1-k);
    run_frame(SIZE);
    for (int k = 0; k < SIZE; k++)
      check($sformatf("frame2_field[%0d]", k), int'(field_of(chain, k)), 'hFF);

    // Abort during the 4th bit of byte 5.
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int i = 0; i < 4; i++) do_byte(200 + i, 8'(8'h30 + i), 8'hFF, 0, 1'b0);
    in_data = 8'h34; in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("abort_mid_shift", int'(ssel), 1);
    #2 rst_n = 1'b0;
    #1;
    check("abort_outputs", int'({ssel, sin, busy, in_ready, out_valid}), 0);
    bad = 0;
    repeat (3) begin
      @(negedge clk);
      if (done || ssel || busy) bad = 1;
    end
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (done || ssel || busy) bad = 1;
    end
    check("abort_no_done", int'(bad), 0);

    // Fresh frame after abort: readback must return whatever the model now holds.
    snap = chain;
    for (int i = 0; i < SIZE; i++) begin
      vec[2*SIZE+i].din    = 8'(8'h40 + i);
      vec[2*SIZE+i].exp_rb = field_of(snap, SIZE-1-i);
      vec[2*SIZE+i].stall  = 0;
    end
    run_frame(2*SIZE);
    for (int k = 0; k < SIZE; k++)
      check($sformatf("frame3_field[%0d]", k), int'(field_of(chain, k)), 'h40 + SIZE-1-k);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
